// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding, stall/flush control and perf counters for the 5-stage pipeline
// Load-use bubbles, bus wait-state freeze with sticky timeout, saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int RA_W        = 5,
  parameter int NUM_FWD     = 2,
  parameter int LU_STALL    = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  exe_rd,
  input  logic             exe_we,
  input  logic             exe_is_load,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_we,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_we,
  input  logic [RA_W-1:0]  wbd_rd,
  input  logic             wbd_we,
  input  logic             redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       fwd1,
  output logic [1:0]       fwd2,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             bus_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam int              WT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WT_W-1:0] WT_MAX  = WT_W'(MEM_TIMEOUT);
  localparam logic [1:0]      LU_INIT = 2'(LU_STALL - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LU       = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  state_t          cur, nxt;
  logic [1:0]      lu_cnt, lu_nxt;
  logic [WT_W-1:0] wait_cnt, wait_nxt;
  logic            lu_hit, mem_stall, stall_inc, flush_inc;

  // Checked oldest-first so the youngest matching producer overwrites the select.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs, input logic use_rs);
    fwd_sel = 2'd0;
    if (use_rs && rs != '0) begin
      if (NUM_FWD >= 3 && wbd_we && wbd_rd == rs) fwd_sel = 2'd3;
      if (NUM_FWD >= 2 && wb_we && wb_rd == rs)   fwd_sel = 2'd2;
      if (mem_we && mem_rd == rs)                 fwd_sel = 2'd1;
    end
  endfunction

  assign fwd1  = fwd_sel(id_rs1, id_use_rs1);
  assign fwd2  = fwd_sel(id_rs2, id_use_rs2);
  assign state = cur;

  assign mem_stall = mem_req & ~mem_ready;
  assign lu_hit    = exe_is_load & exe_we & (exe_rd != '0) &
                     ((id_use_rs1 & (id_rs1 == exe_rd)) | (id_use_rs2 & (id_rs2 == exe_rd)));
  assign wait_nxt  = (wait_cnt == WT_MAX) ? wait_cnt : wait_cnt + WT_W'(1);

  always_comb begin
    nxt          = cur;
    lu_nxt       = lu_cnt;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (mem_stall) begin
      // A freeze during load-use bubbles keeps the remaining bubble count pending.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      stall_inc    = 1'b1;
      nxt          = (cur == S_LU) ? S_LU : S_MEM_WAIT;
    end else if (cur == S_LU) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
      if (lu_cnt <= 2'd1) begin
        nxt    = S_RUN;
        lu_nxt = 2'd0;
      end else begin
        lu_nxt = lu_cnt - 2'd1;
      end
    end else begin
      nxt = S_RUN;
      if (redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (lu_hit) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
        if (LU_STALL > 1) begin
          nxt    = S_LU;
          lu_nxt = LU_INIT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= S_RUN;
      lu_cnt      <= 2'd0;
      wait_cnt    <= '0;
      bus_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      cur    <= nxt;
      lu_cnt <= lu_nxt;
      // wait_cnt counts consecutive frozen cycles, the first one included.
      if (mem_stall) begin
        wait_cnt <= wait_nxt;
        if (wait_nxt == WT_MAX) bus_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
